// File: rtl/fp_round_pack.sv
// Floating-point round-and-pack stage: rounds a normalized mantissa, renormalizes on carry-out and packs {sign, exp, frac}.
// Optional macro ROUND_NEAREST_EVEN_EN selects round-to-nearest-even; the default build truncates.
module fp_round_pack #(
  parameter int unsigned EXPBITS      = 8,
  parameter int unsigned MANTISSABITS = 23
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            InValid,
  output logic                            InReady,
  input  logic                            Sign,
  input  logic [EXPBITS-1:0]              Exp,
  input  logic [MANTISSABITS:0]           Mant,
  input  logic                            Guard,
  input  logic                            RoundBit,
  input  logic                            Sticky,
  input  logic                            OutReady,
  output logic                            OutValid,
  output logic [EXPBITS+MANTISSABITS:0]   Result,
  output logic                            Overflow
);

  localparam int unsigned EW = EXPBITS;
  localparam int unsigned MW = MANTISSABITS;
  localparam int unsigned RW = 1 + EW + MW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    RENORM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state;
  logic           sign_q;
  logic [EW-1:0]  exp_q;
  logic [MW+1:0]  mant_q;
  logic           guard_q;
  logic           round_q;
  logic           sticky_q;

  logic           inc_c;
  logic [MW+1:0]  sum_c;
  logic [EW-1:0]  exp_inc_c;
  logic           zero_c;

`ifdef ROUND_NEAREST_EVEN_EN
  assign inc_c = guard_q & (round_q | sticky_q | mant_q[0]);
`else
  assign inc_c = 1'b0;
`endif

  assign sum_c     = mant_q + (MW+2)'(inc_c);
  assign exp_inc_c = exp_q + EW'(1);
  assign zero_c    = (mant_q == '0) & ~guard_q & ~round_q & ~sticky_q;
  assign InReady   = (state == IDLE) & ~Reset;

  // Overflow takes priority over zero: an all-ones input exponent always saturates.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      OutValid <= 1'b0;
      Overflow <= 1'b0;
      Result   <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            sign_q   <= Sign;
            exp_q    <= Exp;
            mant_q   <= {1'b0, Mant};
            guard_q  <= Guard;
            round_q  <= RoundBit;
            sticky_q <= Sticky;
            state    <= ROUND;
          end
        end
        ROUND: begin
          if (sum_c[MW+1]) begin
            mant_q <= sum_c;
            state  <= RENORM;
          end else begin
            state    <= DONE;
            OutValid <= 1'b1;
            if (&exp_q) begin
              Result   <= {sign_q, {EW{1'b1}}, {MW{1'b0}}};
              Overflow <= 1'b1;
            end else if (zero_c) begin
              Result   <= {sign_q, {(RW-1){1'b0}}};
              Overflow <= 1'b0;
            end else begin
              Result   <= {sign_q, exp_q, sum_c[MW-1:0]};
              Overflow <= 1'b0;
            end
          end
        end
        RENORM: begin
          // Carry-out means the shifted-out bit is zero, so no second rounding pass.
          state    <= DONE;
          OutValid <= 1'b1;
          if ((&exp_inc_c) || (&exp_q)) begin
            Result   <= {sign_q, {EW{1'b1}}, {MW{1'b0}}};
            Overflow <= 1'b1;
          end else begin
            Result   <= {sign_q, exp_inc_c, mant_q[MW:1]};
            Overflow <= 1'b0;
          end
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: randomized operands checked against an arithmetic rounding model.
module tb_fp_round_pack;

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned RW = 1 + EW + MW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic          Sign;
  logic [EW-1:0] Exp;
  logic [MW:0]   Mant;
  logic          Guard;
  logic          RoundBit;
  logic          Sticky;
  logic          OutReady;
  logic          OutValid;
  logic [RW-1:0] Result;
  logic          Overflow;

  fp_round_pack #(.EXPBITS(EW), .MANTISSABITS(MW)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Sign(Sign), .Exp(Exp), .Mant(Mant), .Guard(Guard), .RoundBit(RoundBit),
    .Sticky(Sticky), .OutReady(OutReady), .OutValid(OutValid),
    .Result(Result), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          ovf;
    logic [7:0]    lat;
    logic [31:0]   acc;
    logic [7:0]    hold;
  } exp_t;

  exp_t sbq[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: value-level rounding, halving when the mantissa reaches 2^(MW+1).
  function automatic exp_t model(input logic s, input logic [EW-1:0] e, input logic [MW:0] m,
                                 input logic g, input logic r, input logic st);
    exp_t   x;
    longint mm;
    longint lim;
    int     ee;
    int     emax;
    bit     inc;
`ifdef ROUND_NEAREST_EVEN_EN
    inc = g && (r || st || m[0]);
`else
    inc = 1'b0;
`endif
    lim  = longint'(1) << (MW + 1);
    emax = (1 << EW) - 1;
    mm   = longint'(m) + (inc ? 1 : 0);
    ee   = int'(e);
    x    = '0;
    x.lat = 8'd2;
    if (mm >= lim) begin
      mm    = mm / 2;
      ee    = ee + 1;
      x.lat = 8'd3;
    end
    if (int'(e) == emax || ee == emax) begin
      x.res = {s, {EW{1'b1}}, {MW{1'b0}}};
      x.ovf = 1'b1;
    end else if (m == '0 && !g && !r && !st) begin
      x.res = {s, {(RW-1){1'b0}}};
      x.ovf = 1'b0;
    end else begin
      x.res = {s, ee[EW-1:0], mm[MW-1:0]};
      x.ovf = 1'b0;
    end
    return x;
  endfunction

  task automatic garbage();
    InValid  = 1'($urandom_range(0, 1));
    Sign     = 1'($urandom);
    Exp      = EW'($urandom);
    Mant     = (MW+1)'($urandom);
    Guard    = 1'($urandom);
    RoundBit = 1'($urandom);
    Sticky   = 1'($urandom);
  endtask

  // Junk with random InValid is driven while busy; it must be ignored.
  task automatic send(input logic s, input logic [EW-1:0] e, input logic [MW:0] m,
                      input logic g, input logic r, input logic st, input int hold);
    int   t;
    exp_t x;
    t = 0;
    @(negedge Clock);
    while (!InReady && t < 50) begin
      garbage();
      @(negedge Clock);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 64'(InReady), 64'd1);
    InValid  = 1'b1;
    Sign     = s;
    Exp      = e;
    Mant     = m;
    Guard    = g;
    RoundBit = r;
    Sticky   = st;
    x        = model(s, e, m, g, r, st);
    x.acc    = 32'(cyc);
    x.hold   = 8'(hold);
    sbq.push_back(x);
  endtask

  initial begin : monitor
    exp_t cur;
    bit   active;
    bit   ready_next;
    int   seen;
    OutReady   = 1'b0;
    active     = 1'b0;
    ready_next = 1'b0;
    seen       = 0;
    cur        = '0;
    forever begin
      @(negedge Clock);
      if (mon_en) begin
        if (ready_next) begin
          chk("inready_after_done", 64'(InReady), 64'd1);
          chk("outvalid_after_done", 64'(OutValid), 64'd0);
          ready_next = 1'b0;
          OutReady   = 1'($urandom_range(0, 1));
        end else if (OutValid) begin
          if (!active) begin
            if (sbq.size() == 0) begin
              chk("unexpected_output", 64'(OutValid), 64'd0);
            end else begin
              cur    = sbq.pop_front();
              active = 1'b1;
              seen   = 0;
              chk("latency", 64'(32'(cyc) - cur.acc), 64'(cur.lat));
            end
          end
          if (active) begin
            chk("result", 64'(Result), 64'(cur.res));
            chk("overflow", 64'(Overflow), 64'(cur.ovf));
            chk("inready_in_done", 64'(InReady), 64'd0);
            seen++;
            OutReady = (seen > int'(cur.hold)) && ($urandom_range(0, 2) != 0);
            if (OutReady) begin
              active     = 1'b0;
              ready_next = 1'b1;
            end
          end
        end else begin
          OutReady = 1'($urandom_range(0, 1));
          if (sbq.size() > 0 && (32'(cyc) - sbq[0].acc) > 32'd8) begin
            chk("output_timeout", 64'(OutValid), 64'd1);
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : driver
    int t;
    logic [EW-1:0] e;
    logic [MW:0]   m;
    Reset    = 1'b1;
    InValid  = 1'b0;
    Sign     = 1'b0;
    Exp      = '0;
    Mant     = '0;
    Guard    = 1'b0;
    RoundBit = 1'b0;
    Sticky   = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_outvalid", 64'(OutValid), 64'd0);
    chk("reset_result", 64'(Result), 64'd0);
    chk("reset_overflow", 64'(Overflow), 64'd0);
    chk("reset_inready_low", 64'(InReady), 64'd0);
    Reset = 1'b0;
    #1;
    chk("inready_after_reset", 64'(InReady), 64'd1);
    mon_en = 1'b1;

    send(1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0, 1'b0, 0);
    send(1'b0, 8'h7F, 24'h800001, 1'b1, 1'b0, 1'b0, 0);
    send(1'b0, 8'h7F, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 5);
    send(1'b1, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1, 1'b0, 0);
    send(1'b1, 8'hFF, 24'h800000, 1'b0, 1'b0, 1'b0, 0);
    send(1'b1, 8'h00, 24'h000000, 1'b0, 1'b0, 1'b0, 0);
    send(1'b0, 8'h80, 24'h800000, 1'b1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0:       e = 8'hFE;
        1:       e = 8'hFF;
        2:       e = 8'h00;
        default: e = EW'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       m = '0;
        1, 2:    m = 24'hFFFFFF;
        default: m = {1'b1, MW'($urandom)};
      endcase
      send(1'($urandom), e, m, 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0) ? 5 : 0);
    end

    @(negedge Clock);
    InValid = 1'b0;
    t = 0;
    while ((sbq.size() != 0 || !InReady) && t < 100) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 100) chk("drain_timeout", 64'(sbq.size()), 64'd0);
    repeat (2) @(negedge Clock);
    mon_en = 1'b0;

    // Reset while the operand sits in ROUND: it must be discarded.
    @(negedge Clock);
    chk("pre_reset_inready", 64'(InReady), 64'd1);
    InValid = 1'b1;
    Sign    = 1'b0;
    Exp     = 8'h7F;
    Mant    = 24'h800000;
    Guard   = 1'b0;
    RoundBit = 1'b0;
    Sticky  = 1'b0;
    @(negedge Clock);
    InValid = 1'b0;
    chk("round_inready", 64'(InReady), 64'd0);
    Reset = 1'b1;
    @(negedge Clock);
    chk("midop_reset_outvalid", 64'(OutValid), 64'd0);
    chk("midop_reset_result", 64'(Result), 64'd0);
    chk("midop_reset_inready", 64'(InReady), 64'd0);
    Reset = 1'b0;
    #1;
    chk("midop_reset_inready_after", 64'(InReady), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      chk("discarded_no_output", 64'(OutValid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_round_pack.md
FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 SHALL have parameter EXPBITS, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSABITS, default 23, stored fraction width.
REQ-003 SHALL have port Clock, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port InValid, input, 1, upstream operand valid.
REQ-006 SHALL have port InReady, output, 1, block can accept an operand.
REQ-007 SHALL have port Sign, input, 1, result sign.
REQ-008 SHALL have port Exp, input, EXPBITS, normalized biased exponent.
REQ-009 SHALL have port Mant, input, MANTISSABITS+1, normalized mantissa; bit MANTISSABITS is the hidden bit.
REQ-010 SHALL have port Guard, input, 1, first bit below the LSB.
REQ-011 SHALL have port RoundBit, input, 1, second bit below the LSB.
REQ-012 SHALL have port Sticky, input, 1, OR of all lower discarded bits.
REQ-013 SHALL have port OutReady, input, 1, downstream accepts the result.
REQ-014 SHALL have port OutValid, output, 1, Result valid.
REQ-015 SHALL have port Result, output, 1+EXPBITS+MANTISSABITS, packed {sign, exponent, fraction}.
REQ-016 SHALL have port Overflow, output, 1, result saturated to infinity; valid with OutValid.

Function
REQ-017 SHALL implement an FSM with states IDLE, ROUND, RENORM and DONE.
REQ-018 InReady SHALL be 1 only in IDLE with Reset low.
REQ-019 SHALL capture Sign, Exp, Mant, Guard, RoundBit and Sticky, and move to ROUND, when InValid&&InReady at a rising edge; InValid SHALL be ignored in all other states.
REQ-020 ROUND SHALL form the mantissa as Mant+inc in MANTISSABITS+2 bits, where inc is defined by REQ-031/REQ-032.
REQ-021 ROUND SHALL move to RENORM if carry bit MANTISSABITS+1 is set; otherwise it SHALL move to DONE.
REQ-022 RENORM SHALL shift the mantissa right by 1, increment the exponent by 1 and move to DONE; no second rounding is performed because the shifted-out bit is 0.
REQ-023 Latency: with acceptance in cycle N, OutValid SHALL be 1 in cycle N+2 without renormalization and in cycle N+3 with renormalization.
REQ-024 Overflow: if the final exponent equals all-ones, or the captured Exp equals all-ones, Result SHALL be {Sign, all-ones, zero fraction} and Overflow SHALL be 1.
REQ-025 Zero: if the captured Mant is 0 and Guard, RoundBit and Sticky are all 0, Result SHALL be {Sign, 0, 0} and Overflow SHALL be 0.
REQ-026 Otherwise Result SHALL be {Sign, exponent, mantissa[MANTISSABITS-1:0]}; the hidden bit SHALL be dropped.
REQ-027 DONE SHALL hold OutValid=1, with Result and Overflow stable, until OutReady=1.
REQ-028 DONE SHALL move to IDLE on the edge where OutReady=1; InReady SHALL be 1 the following cycle; there is no same-cycle accept.
REQ-029 OutValid SHALL be 0 in IDLE, ROUND and RENORM.

Reset
REQ-030 When Reset=1 at a rising edge, from any state including mid-operation, the FSM SHALL go to IDLE and clear OutValid=0, Overflow=0 and Result=0; the captured operand SHALL be discarded; InReady SHALL be 0 while Reset is high.

Configuration
REQ-031 With ROUND_NEAREST_EVEN_EN defined, inc SHALL be Guard&&(RoundBit||Sticky||Mant[0]) (round to nearest, ties to even).
REQ-032 Without ROUND_NEAREST_EVEN_EN, inc SHALL be 0 (truncation); RENORM is then unreachable.

Verification (EXPBITS=8, MANTISSABITS=23)
REQ-033 Exp=8'h7F, Mant=24'h800000, G/R/S=0 -> Result=32'h3F800000 at N+2, Overflow=0.
REQ-034 Exp=8'h7F, Mant=24'h800001, G=1, R=0, S=0 -> Result=32'h3F800002 with the macro defined, 32'h3F800001 without.
REQ-035 Exp=8'h7F, Mant=24'hFFFFFF, G=1, S=1, macro defined -> RENORM visited, Result=32'h40000000 at N+3.
REQ-036 Sign=1, Exp=8'hFE, Mant=24'hFFFFFF, G=1, R=1, macro defined -> Result=32'hFF800000, Overflow=1.
REQ-037 OutReady=0 for 5 cycles in DONE -> Result stable, InReady=0, a new InValid ignored; OutReady=1 -> IDLE, InReady=1 next cycle.
REQ-038 Reset pulsed while in ROUND -> OutValid=0, state IDLE, InReady=1 the first cycle after Reset falls.
